if_id_queue: RTL
================

// Module: if_id_queue
// PURPOSE
//  Instruction queue between the IF stage and the ID stage. Decouples fetch from
//  decode stalls by buffering up to DEPTH fetched entries {inst, pc4, halted}.
//  Supports valid/ready flow control and branch/jump flush. Tracks the halt
//  instruction (32'h0000_000c) and stops accepting fetches after it.
// PARAMETERS
//  DEPTH   4    entries; power of two, >= 2
//  AW      $clog2(DEPTH)  pointer width (derived, not overridden)
// PORTS
//  clk         in   1      rising-edge clock, the only clock
//  rst_b       in   1      reset, synchronous, active-low
//  if_valid    in   1      IF presents a fetched entry this cycle
//  if_inst     in   32     fetched instruction
//  if_pc4      in   32     PC+4 of fetched instruction
//  if_halted   in   1      IF flags if_inst as the halt instruction
//  if_ready    out  1      queue accepts an entry; drives IF pc_enable
//  flush       in   1      taken branch/jump resolved: discard all entries
//  id_ready    in   1      ID consumes head entry (0 = decode stall)
//  id_valid    out  1      head entry valid
//  id_inst     out  32     head instruction
//  id_pc4      out  32     head PC+4
//  id_halted   out  1      head entry is the halt instruction
//  count       out  AW+1   occupied entries, 0..DEPTH
//  halt_seen   out  1      halt entry accepted and not flushed
// BEHAVIOUR
//  - Reset (rst_b=0 at edge): rd_ptr=wr_ptr=0, count=0, halt_seen=0; outputs
//    follow: id_valid=0, id_inst=0, id_pc4=0, id_halted=0, if_ready=1.
//    Reset overrides flush, push and pop in the same cycle.
//  - push = if_valid & if_ready & ~flush; pop = id_valid & id_ready & ~flush.
//  - if_ready = (count != DEPTH) & ~halt_seen. Combinational from state only;
//    no dependence on id_ready (no pass-through when full).
//  - id_valid = (count != 0). id_* are a show-ahead view of entry rd_ptr;
//    when count==0 id_inst=0 (nop), id_pc4=0, id_halted=0.
//  - Latency: entry pushed at edge N is on id_* after edge N when queue was
//    empty; otherwise after all older entries are popped.
//  - Simultaneous push & pop (0<count<DEPTH): both pointers advance, count unchanged.
//  - Empty: pop impossible (id_valid=0); push only. Full: if_ready=0; pop only.
//  - Pointers are AW bits and wrap modulo DEPTH; count is AW+1 bits, never
//    exceeds DEPTH nor goes below 0.
//  - Flush (rst_b=1, flush=1 at edge): pointers and count to 0, halt_seen=0;
//    same-cycle push and pop are discarded. id_valid=0 the following cycle.
//  - Halt: push with if_halted=1 sets halt_seen at that edge; if_ready=0 from the
//    next cycle; older and halt entry still drain to ID normally. halt_seen
//    clears only on flush or reset.
//  - Entry storage: DEPTH x 65 bits, written only on push, no reset needed on data.
// TESTING
//  1 Reset: rst_b=0 two cycles -> count=0, id_valid=0, id_inst=0, if_ready=1.
//  2 Fill: id_ready=0, push inst 0x20080001..0x20080004 (pc4 4,8,12,16) ->
//    count=4, if_ready=0, id_inst=0x20080001, id_pc4=4; 5th if_valid ignored.
//  3 Drain: then id_ready=1, if_valid=0 -> id_inst 0x..01..0x..04 on 4
//    consecutive cycles, then id_valid=0, count=0.
//  4 Stream: if_valid=id_ready=1 for 20 cycles, pc4 4,8,... -> count stays 1
//    after first edge, id_pc4 sequence in order, no gaps; pointers wrap.
//  5 Flush: count=3, flush=1 with if_valid=1 and id_ready=1 -> next cycle
//    count=0, id_valid=0; following push appears at head.
//  6 Halt: push 0x00000020 then 0x0000000c (if_halted=1) -> halt_seen=1,
//    if_ready=0; both drain, id_halted=1 on second; flush clears halt_seen.

Source files
------------

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : Show-ahead IF->ID instruction queue with valid/ready flow
//               control, branch/jump flush and halt-instruction tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          if_valid,
    input  logic [31:0]   if_inst,
    input  logic [31:0]   if_pc4,
    input  logic          if_halted,
    output logic          if_ready,
    input  logic          flush,
    input  logic          id_ready,
    output logic          id_valid,
    output logic [31:0]   id_inst,
    output logic [31:0]   id_pc4,
    output logic          id_halted,
    output logic [AW:0]   count,
    output logic          halt_seen
);

    localparam logic [AW:0]   C_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
    localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);

    logic [64:0]   mem_q [DEPTH];
    logic [64:0]   mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          halt_seen_q, halt_seen_d;

    logic          w_push;
    logic          w_pop;
    logic [64:0]   w_head;

    assign if_ready = (count_q != C_FULL) && !halt_seen_q;
    assign id_valid = (count_q != '0);
    assign w_push   = if_valid && if_ready && !flush;
    assign w_pop    = id_valid && id_ready && !flush;

    // Head entry is forced to a nop when the queue is empty.
    assign w_head    = id_valid ? mem_q[rd_ptr_q] : 65'd0;
    assign id_inst   = w_head[64:33];
    assign id_pc4    = w_head[32:1];
    assign id_halted = w_head[0];
    assign count     = count_q;
    assign halt_seen = halt_seen_q;

    always_comb begin
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        halt_seen_d = halt_seen_q;
        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            halt_seen_d = 1'b0;
        end else begin
            if (w_push) begin
                mem_d[wr_ptr_q] = {if_inst, if_pc4, if_halted};
                wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
                if (if_halted) begin
                    halt_seen_d = 1'b1;
                end
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                count_d = count_q + C_CNT_ONE;
            end else if (w_pop && !w_push) begin
                count_d = count_q - C_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            halt_seen_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            halt_seen_q <= halt_seen_d;
        end
    end

    // Payload storage carries no reset; id_* are masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire
